// File: rtl/branch_resolution_unit_if.sv
// Decode-stage branch resolver bus: decode/prediction inputs and predictor update/redirect outputs.
interface branch_resolution_unit_if #(
    parameter int CNT_W = 16
);
    logic             enable;
    logic             is_branch;
    logic             is_BR;
    logic [2:0]       cond;
    logic [8:0]       imm9;
    logic [15:0]      reg_target;
    logic [2:0]       flags;
    logic             flags_pending;
    logic [15:0]      IF_ID_PC_curr;
    logic [1:0]       IF_ID_prediction;
    logic [15:0]      IF_ID_predicted_target;
    logic             actual_taken;
    logic [15:0]      actual_target;
    logic             wen_BHT;
    logic             wen_BTB;
    logic             update_PC;
    logic             flush;
    logic             stall_req;
    logic [CNT_W-1:0] branch_count;
    logic [CNT_W-1:0] mispredict_count;

    modport slave (
        input  enable, is_branch, is_BR, cond, imm9, reg_target, flags, flags_pending,
               IF_ID_PC_curr, IF_ID_prediction, IF_ID_predicted_target,
        output actual_taken, actual_target, wen_BHT, wen_BTB, update_PC, flush, stall_req,
               branch_count, mispredict_count
    );

    modport master (
        output enable, is_branch, is_BR, cond, imm9, reg_target, flags, flags_pending,
               IF_ID_PC_curr, IF_ID_prediction, IF_ID_predicted_target,
        input  actual_taken, actual_target, wen_BHT, wen_BTB, update_PC, flush, stall_req,
               branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_resolution_unit.sv
// Resolves B/BR in decode against ZVN flags, compares with the pipelined prediction and
// drives predictor update/redirect strobes; waits for in-flight flags, one update per branch.
module branch_resolution_unit #(
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    branch_resolution_unit_if.slave bus
);
    typedef enum logic {
        RESOLVE = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t           r_state;
    logic             r_done;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispred_cnt;

    logic        w_ctl;
    logic        w_z;
    logic        w_v;
    logic        w_n;
    logic        w_cond_true;
    logic [15:0] w_pc_plus2;
    logic [15:0] w_b_target;
    logic        w_valid;
    logic        w_taken;
    logic [15:0] w_target;
    logic        w_wait;
    logic        w_fire;
    logic        w_target_miss;
    logic        w_update;
    logic        w_btb;
    logic        w_stall;

    assign w_ctl = bus.is_branch | bus.is_BR;
    assign w_z   = bus.flags[2];
    assign w_v   = bus.flags[1];
    assign w_n   = bus.flags[0];

    always_comb begin
        w_cond_true = 1'b0;
        case (bus.cond)
            3'b000:  w_cond_true = ~w_z;
            3'b001:  w_cond_true = w_z;
            3'b010:  w_cond_true = ~w_z & ~w_n;
            3'b011:  w_cond_true = w_n;
            3'b100:  w_cond_true = w_z | (~w_z & ~w_n);
            3'b101:  w_cond_true = w_n | w_z;
            3'b110:  w_cond_true = w_v;
            default: w_cond_true = 1'b1;
        endcase
    end

    assign w_pc_plus2 = bus.IF_ID_PC_curr + 16'd2;
    assign w_b_target = w_pc_plus2 + {{6{bus.imm9[8]}}, bus.imm9, 1'b0};

    assign w_valid  = (r_state == RESOLVE) & w_ctl;
    assign w_taken  = w_valid & w_cond_true;
    assign w_target = !w_taken ? w_pc_plus2 : (bus.is_BR ? bus.reg_target : w_b_target);

    // Unconditional branches never depend on flags, so they resolve even with flags in flight.
    assign w_wait = w_ctl & bus.flags_pending & (bus.cond != 3'b111);
    assign w_fire = rst_n & (r_state == RESOLVE) & w_ctl & ~w_wait & ~r_done;

    assign w_target_miss = bus.IF_ID_predicted_target != w_target;
    assign w_update = w_fire & ((bus.IF_ID_prediction[1] != w_taken) | (w_taken & w_target_miss));
    assign w_btb    = w_fire & w_taken & (w_target_miss | ~bus.IF_ID_prediction[1]);
    assign w_stall  = rst_n & ((r_state == HOLD) | ((r_state == RESOLVE) & w_wait));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= RESOLVE;
            r_done        <= 1'b0;
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            case (r_state)
                RESOLVE: if (w_wait) r_state <= HOLD;
                HOLD:    if (!bus.flags_pending) r_state <= RESOLVE;
                default: r_state <= RESOLVE;
            endcase

            // A resolved branch held in decode must not strobe the predictor again.
            if (bus.enable)
                r_done <= 1'b0;
            else if (w_fire)
                r_done <= 1'b1;

            if (w_fire && (r_branch_cnt != '1))
                r_branch_cnt <= r_branch_cnt + 1'b1;
            if (w_update && (r_mispred_cnt != '1))
                r_mispred_cnt <= r_mispred_cnt + 1'b1;
        end
    end

    assign bus.actual_taken     = w_taken;
    assign bus.actual_target    = w_target;
    assign bus.wen_BHT          = w_fire;
    assign bus.wen_BTB          = w_btb;
    assign bus.update_PC        = w_update;
    assign bus.flush            = w_update;
    assign bus.stall_req        = w_stall;
    assign bus.branch_count     = r_branch_cnt;
    assign bus.mispredict_count = r_mispred_cnt;
endmodule
